// File: rtl/bcd_div_checker.sv
// Streams a BCD number MSD-first and reports divisibility by 3 and 11.
// Optional macro BCD_DIV_DIGIT_CHECK_EN flags digits above 9 via bcd_err.
module bcd_div_checker #(
  parameter  int MAX_DIGITS = 4,
  localparam int CW = $clog2(MAX_DIGITS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          digit_valid,
  input  logic [3:0]    digit,
  input  logic          digit_last,
  output logic          digit_ready,
  output logic          result_valid,
  input  logic          result_ready,
  output logic          div3,
  output logic          div11,
  output logic          result,
  output logic [CW-1:0] digit_count,
  output logic          ovf,
  output logic          bcd_err
);

  typedef enum logic [1:0] {IDLE, ACCUM, RESULT} state_t;

  state_t        r_state;
  logic [1:0]    r_r3;
  logic [3:0]    r_r11;
  logic [CW-1:0] r_count;
  logic          r_ovf;
  logic          r_err;
  logic          r_outValid;
  logic          r_outDiv3;
  logic          r_outDiv11;
  logic          r_outResult;
  logic [CW-1:0] r_outCount;
  logic          r_outOvf;
  logic          r_outErr;

  logic          w_accept;
  logic          w_fresh;
  logic          w_badDigit;
  logic [1:0]    w_r3Base;
  logic [3:0]    w_r11Base;
  logic [CW-1:0] w_cntBase;
  logic          w_ovfBase;
  logic          w_errBase;
  logic          w_ovfNow;
  logic [4:0]    w_sum3;
  logic [4:0]    w_sum11;
  logic [1:0]    w_r3Upd;
  logic [3:0]    w_r11Upd;
  logic [CW-1:0] w_cntUpd;
  logic          w_ovfUpd;
  logic          w_errUpd;
  logic          w_clean;

`ifdef BCD_DIV_DIGIT_CHECK_EN
  assign w_badDigit = (digit > 4'd9);
`else
  assign w_badDigit = 1'b0;
`endif

  assign digit_ready = !rst && (r_state != RESULT);
  assign w_accept    = digit_valid && digit_ready;

  // A digit accepted in IDLE starts a new number, so it builds on zeroed state.
  always_comb begin
    w_fresh   = (r_state == IDLE);
    w_r3Base  = w_fresh ? 2'd0 : r_r3;
    w_r11Base = w_fresh ? 4'd0 : r_r11;
    w_cntBase = w_fresh ? '0 : r_count;
    w_ovfBase = w_fresh ? 1'b0 : r_ovf;
    w_errBase = w_fresh ? 1'b0 : r_err;
    w_ovfNow  = (w_cntBase == CW'(MAX_DIGITS));
    w_sum3    = 5'(w_r3Base) + 5'(digit);
    w_sum11   = 5'(digit) + 5'd11 - 5'(w_r11Base);
    w_r3Upd   = w_ovfNow ? w_r3Base : 2'(w_sum3 % 5'd3);
    w_r11Upd  = w_ovfNow ? w_r11Base : 4'(w_sum11 % 5'd11);
    w_cntUpd  = w_ovfNow ? w_cntBase : w_cntBase + CW'(1);
    w_ovfUpd  = w_ovfBase | w_ovfNow;
    w_errUpd  = w_errBase | w_badDigit;
    w_clean   = !w_ovfUpd && !w_errUpd;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_r3        <= '0;
      r_r11       <= '0;
      r_count     <= '0;
      r_ovf       <= 1'b0;
      r_err       <= 1'b0;
      r_outValid  <= 1'b0;
      r_outDiv3   <= 1'b0;
      r_outDiv11  <= 1'b0;
      r_outResult <= 1'b0;
      r_outCount  <= '0;
      r_outOvf    <= 1'b0;
      r_outErr    <= 1'b0;
    end else begin
      case (r_state)
        IDLE, ACCUM: begin
          if (w_accept) begin
            r_r3    <= w_r3Upd;
            r_r11   <= w_r11Upd;
            r_count <= w_cntUpd;
            r_ovf   <= w_ovfUpd;
            r_err   <= w_errUpd;
            if (digit_last) begin
              r_state     <= RESULT;
              r_outValid  <= 1'b1;
              r_outDiv3   <= w_clean && (w_r3Upd == 2'd0);
              r_outDiv11  <= w_clean && (w_r11Upd == 4'd0);
              r_outResult <= w_clean && ((w_r3Upd == 2'd0) || (w_r11Upd == 4'd0));
              r_outCount  <= w_cntUpd;
              r_outOvf    <= w_ovfUpd;
              r_outErr    <= w_errUpd;
            end else begin
              r_state <= ACCUM;
            end
          end
        end
        RESULT: begin
          if (result_ready) begin
            r_state     <= IDLE;
            r_outValid  <= 1'b0;
            r_outDiv3   <= 1'b0;
            r_outDiv11  <= 1'b0;
            r_outResult <= 1'b0;
            r_outCount  <= '0;
            r_outOvf    <= 1'b0;
            r_outErr    <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign result_valid = r_outValid;
  assign div3         = r_outDiv3;
  assign div11        = r_outDiv11;
  assign result       = r_outResult;
  assign digit_count  = r_outCount;
  assign ovf          = r_outOvf;
  assign bcd_err      = r_outErr;

endmodule

// File: tb/tb_bcd_div_checker.sv
// Testbench for bcd_div_checker: directed vector table, reset/hold sequences,
// and random numbers checked against an integer-arithmetic reference model.
module tb_bcd_div_checker;

  localparam int MAXD = 4;
  localparam int CW   = $clog2(MAXD + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          digit_valid;
  logic [3:0]    digit;
  logic          digit_last;
  logic          digit_ready;
  logic          result_valid;
  logic          result_ready;
  logic          div3;
  logic          div11;
  logic          result;
  logic [CW-1:0] digit_count;
  logic          ovf;
  logic          bcd_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string            name;
    int               n;
    logic [5:0][3:0]  d;
    logic             e3;
    logic             e11;
    logic             eres;
    int               ecnt;
    logic             eovf;
    logic             eerr;
  } vec_t;

  vec_t vecs[$];

  bcd_div_checker #(.MAX_DIGITS(MAXD)) dut (
    .clk(clk), .rst(rst), .digit_valid(digit_valid), .digit(digit),
    .digit_last(digit_last), .digit_ready(digit_ready),
    .result_valid(result_valid), .result_ready(result_ready),
    .div3(div3), .div11(div11), .result(result), .digit_count(digit_count),
    .ovf(ovf), .bcd_err(bcd_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  function automatic vec_t mk(input string name, input int n, input int d0, input int d1,
                              input int d2, input int d3, input int d4, input int d5,
                              input bit e3, input bit e11, input bit eres, input int ecnt,
                              input bit eovf, input bit eerr);
    vec_t v;
    v.name = name; v.n = n;
    v.d[0] = 4'(d0); v.d[1] = 4'(d1); v.d[2] = 4'(d2);
    v.d[3] = 4'(d3); v.d[4] = 4'(d4); v.d[5] = 4'(d5);
    v.e3 = e3; v.e11 = e11; v.eres = eres; v.ecnt = ecnt; v.eovf = eovf; v.eerr = eerr;
    return v;
  endfunction

  // Reference: the number's value from its first MAXD digits, tested with plain % arithmetic.
  function automatic vec_t model(input vec_t vin);
    vec_t   v = vin;
    longint val = 0;
    bit     bad = 0;
    for (int i = 0; i < v.n; i++) begin
      if (v.d[i] > 9) bad = 1;
      if (i < MAXD) val = val * 10 + longint'(v.d[i]);
    end
    v.eovf = (v.n > MAXD);
    v.ecnt = (v.n > MAXD) ? MAXD : v.n;
`ifdef BCD_DIV_DIGIT_CHECK_EN
    v.eerr = bad;
`else
    v.eerr = 0;
`endif
    v.e3   = !v.eovf && !v.eerr && (val % 3 == 0);
    v.e11  = !v.eovf && !v.eerr && (val % 11 == 0);
    v.eres = v.e3 | v.e11;
    return v;
  endfunction

  task automatic sendDigits(input vec_t v, input int n, input bit lastOnFinal);
    for (int i = 0; i < n; i++) begin
      digit_valid = 1'b1;
      digit       = v.d[i];
      digit_last  = lastOnFinal && (i == n - 1);
      #1;
      checkOutput({v.name, " digit_ready"}, int'(digit_ready), 1);
      @(posedge clk); #1;
    end
    digit_valid = 1'b0;
    digit_last  = 1'b0;
  endtask

  task automatic checkResult(input vec_t v);
    checkOutput({v.name, " result_valid"}, int'(result_valid), 1);
    checkOutput({v.name, " div3"},         int'(div3),         int'(v.e3));
    checkOutput({v.name, " div11"},        int'(div11),        int'(v.e11));
    checkOutput({v.name, " result"},       int'(result),       int'(v.eres));
    checkOutput({v.name, " digit_count"},  int'(digit_count),  v.ecnt);
    checkOutput({v.name, " ovf"},          int'(ovf),          int'(v.eovf));
    checkOutput({v.name, " bcd_err"},      int'(bcd_err),      int'(v.eerr));
  endtask

  task automatic checkCleared(input string name);
    checkOutput({name, " idle valid"}, int'(result_valid), 0);
    checkOutput({name, " idle fields"},
                int'({div3, div11, result, ovf, bcd_err}) + int'(digit_count), 0);
    checkOutput({name, " idle ready"}, int'(digit_ready), 1);
  endtask

  task automatic releaseResult(input string name);
    result_ready = 1'b1;
    @(posedge clk); #1;
    result_ready = 1'b0;
    checkCleared(name);
  endtask

  task automatic applyStimulus(input vec_t v);
    sendDigits(v, v.n, 1'b1);
    checkResult(v);
    releaseResult(v.name);
  endtask

  initial begin
    vec_t v;
    rst = 1'b1; digit_valid = 1'b0; digit = '0; digit_last = 1'b0; result_ready = 1'b0;
    @(posedge clk); #1;
    checkOutput("reset digit_ready", int'(digit_ready), 0);
    checkOutput("reset result_valid", int'(result_valid), 0);
    rst = 1'b0; #1;
    checkCleared("post-reset");

    vecs.push_back(mk("4353",  4, 4,3,5,3,0,0, 1,0,1, 4, 0,0));
    vecs.push_back(mk("3542",  4, 3,5,4,2,0,0, 0,1,1, 4, 0,0));
    vecs.push_back(mk("3578",  4, 3,5,7,8,0,0, 0,0,0, 4, 0,0));
    vecs.push_back(mk("9999",  4, 9,9,9,9,0,0, 1,1,1, 4, 0,0));
    vecs.push_back(mk("0",     1, 0,0,0,0,0,0, 1,1,1, 1, 0,0));
    vecs.push_back(mk("0363",  4, 0,3,6,3,0,0, 1,1,1, 4, 0,0));
    vecs.push_back(mk("7",     1, 7,0,0,0,0,0, 0,0,0, 1, 0,0));
    vecs.push_back(mk("33",    2, 3,3,0,0,0,0, 1,1,1, 2, 0,0));
    vecs.push_back(mk("12345", 5, 1,2,3,4,5,0, 0,0,0, 4, 1,0));
    vecs.push_back(mk("999999",6, 9,9,9,9,9,9, 0,0,0, 4, 1,0));
    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Result held off for 5 cycles while a competing digit is offered.
    v = vecs[0];
    v.name = "hold";
    sendDigits(v, v.n, 1'b1);
    checkResult(v);
    digit_valid = 1'b1; digit = 4'd9; digit_last = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checkOutput("hold digit_ready", int'(digit_ready), 0);
      checkResult(v);
    end
    digit_valid = 1'b0; digit_last = 1'b0;
    releaseResult("hold");

    // Reset mid-number abandons it; the next number starts fresh.
    v = mk("rst-mid", 2, 3,5,0,0,0,0, 0,0,0, 0, 0,0);
    sendDigits(v, 2, 1'b0);
    checkOutput("rst-mid no result", int'(result_valid), 0);
    rst = 1'b1; #1;
    checkOutput("rst-mid ready low", int'(digit_ready), 0);
    @(posedge clk); #1;
    rst = 1'b0; #1;
    checkCleared("rst-mid");
    applyStimulus(mk("66", 2, 6,6,0,0,0,0, 1,1,1, 2, 0,0));

    // Reset while a result is pending drops it.
    v = mk("rst-res", 2, 3,3,0,0,0,0, 1,1,1, 2, 0,0);
    sendDigits(v, 2, 1'b1);
    checkResult(v);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; #1;
    checkCleared("rst-res");

    applyStimulus(model(mk("1A2", 3, 1,10,2,0,0,0, 0,0,0, 0, 0,0)));

    for (int k = 0; k < 40; k++) begin
      v.name = $sformatf("rand%0d", k);
      v.n = int'($urandom_range(1, 6));
      for (int i = 0; i < 6; i++)
        v.d[i] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                             : 4'($urandom_range(0, 9));
      applyStimulus(model(v));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
